// File: rtl/sync_ram_wide_rd.sv
// Single-clock simple dual-port storage: narrow write port, registered wide read
// that returns RD2WR consecutive words with the oldest word in the MSBs.
module sync_ram_wide_rd #(
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int WR_WIDTH   = 8,
   parameter int RD_WIDTH   = 32,
   parameter int RD2WR      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WR_WIDTH-1:0]   wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [RD_WIDTH-1:0]   rdata
);

   (* ram_style = "block" *) logic [WR_WIDTH-1:0] mem_q [DEPTH];

   logic [RD_WIDTH-1:0] rdata_d;
   logic [RD_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // raddr is group-aligned, so raddr+i never crosses the end of the array.
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < RD2WR; i++) begin
         rdata_d[RD_WIDTH-1-i*WR_WIDTH -: WR_WIDTH] = mem_q[raddr + ADDR_WIDTH'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_wide_rd.sv
// Narrow-write / wide-read synchronous FIFO with registered flags and counts.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through on the read side.
module sync_fifo_wide_rd #(
   parameter int FIFO_DEPTH      = 64,
   parameter int FIFO_ADDR_WIDTH = 6,
   parameter int WR_WIDTH        = 8,
   parameter int RD_WIDTH        = 32,
   parameter int RD2WR           = 4,
   parameter int ALMOST_FULL_TH  = 56,
   parameter int ALMOST_EMPTY_TH = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WR_WIDTH-1:0]      wr_data,
   input  logic                     rd_en,
   output logic [RD_WIDTH-1:0]      rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [FIFO_ADDR_WIDTH:0] wr_cnt,
   output logic [FIFO_ADDR_WIDTH:0] rd_cnt,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW         = FIFO_ADDR_WIDTH + 1;
   localparam int RD2WR_LOG2 = (RD2WR > 1) ? $clog2(RD2WR) : 0;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] rcnt_q, rcnt_d;
   logic          full_q, empty_q, afull_q, aempty_q;
   logic          valid_q, valid_d, empty_d;
   logic          ovf_q, unf_q;
   logic          wr_acc, rd_acc, ram_re;

   // Acceptance uses only the registered flags: no pass-through either way.
   assign wr_acc = wr_en && !full_q;
   assign rd_acc = rd_en && !empty_q;

`ifdef SYNC_FIFO_FWFT_EN
   logic [PW-1:0] stored;

   always_comb begin
      stored   = wr_ptr_q - rd_ptr_q;
      ram_re   = (stored >= PW'(RD2WR)) && (!valid_q || rd_acc);
      valid_d  = ram_re || (valid_q && !rd_acc);
      wr_ptr_d = wr_ptr_q + (wr_acc ? PW'(1) : PW'(0));
      rd_ptr_d = rd_ptr_q + (ram_re ? PW'(RD2WR) : PW'(0));
      cnt_d    = wr_ptr_d - rd_ptr_d + (valid_d ? PW'(RD2WR) : PW'(0));
      rcnt_d   = cnt_d >> RD2WR_LOG2;
      empty_d  = !valid_d;
   end
`else
   always_comb begin
      ram_re   = rd_acc;
      valid_d  = rd_acc;
      wr_ptr_d = wr_ptr_q + (wr_acc ? PW'(1) : PW'(0));
      rd_ptr_d = rd_ptr_q + (ram_re ? PW'(RD2WR) : PW'(0));
      cnt_d    = wr_ptr_d - rd_ptr_d;
      rcnt_d   = cnt_d >> RD2WR_LOG2;
      empty_d  = (cnt_d < PW'(RD2WR));
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rcnt_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rcnt_q   <= rcnt_d;
         full_q   <= (cnt_d == PW'(FIFO_DEPTH));
         empty_q  <= empty_d;
         afull_q  <= (cnt_d >= PW'(ALMOST_FULL_TH));
         aempty_q <= (rcnt_d <= PW'(ALMOST_EMPTY_TH));
         valid_q  <= valid_d;
         ovf_q    <= wr_en && full_q;
         unf_q    <= rd_en && empty_q;
      end
   end

   sync_ram_wide_rd #(
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH),
      .WR_WIDTH   (WR_WIDTH),
      .RD_WIDTH   (RD_WIDTH),
      .RD2WR      (RD2WR)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc && !rst),
      .waddr (wr_ptr_q[FIFO_ADDR_WIDTH-1:0]),
      .wdata (wr_data),
      .re    (ram_re && !rst),
      .raddr (rd_ptr_q[FIFO_ADDR_WIDTH-1:0]),
      .rdata (rd_data)
   );

   assign rd_valid     = valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign wr_cnt       = cnt_q;
   assign rd_cnt       = rcnt_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule
